mac_pipe: RTL and testbench
===========================

Name: mac_pipe

Overview:
- Parametrised, pipelined multiply-accumulate unit; successor to the single-width 64-bit MAC.
- Accepts operand pairs over a valid/ready stream and accumulates their products into a wide accumulator.
- Each accumulation group is bounded by `first`/`last` tags. The result is emitted on an output valid/ready stream.
- Adds signed mode, optional saturation and a sticky overflow flag. Sits in the datapath between operand sequencers and result consumers (dot-product, filter taps).

Parameters:
- DATA_W, 64: operand width (a, b).
- ACC_W, 128: accumulator/result width. Must satisfy ACC_W >= 2*DATA_W; elaboration error otherwise.
- SIGNED, 0: 0 = unsigned operands and accumulation; 1 = two's-complement.
- SATURATE, 0: 0 = accumulator wraps on overflow; 1 = clamps to max/min representable ACC_W value.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  DATA_W  multiplicand.
- b  in  DATA_W  multiplier.
- first  in  1  beat starts a new accumulation group.
- last  in  1  beat ends the group; triggers result emission.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  ACC_W  accumulated sum of the group.
- overflow  out  1  at least one overflow occurred in the group; qualified by out_valid.

Behaviour:
- Reset (reset=0, async): clear all pipeline valid bits, operand/product regs, accumulator, result, overflow, out_valid. in_ready=0 while reset is asserted and 1 in the first cycle after release. Reset mid-group discards the partial sum with no output.
- Handshake:
  - Beat accepted on an edge where in_valid && in_ready.
  - Result transferred on an edge where out_valid && out_ready.
  - stall = out_valid && !out_ready; in_ready = !stall.
  - While stalled, all pipeline stages and the accumulator hold.
- Pipeline, with a beat accepted at edge E0:
  - S1 (E0): register a, b, first, last, valid.
  - S2 (E1): product = a*b at 2*DATA_W, zero-extended (SIGNED=0) or sign-extended (SIGNED=1) to ACC_W.
  - S3 (E2): acc <= (first ? product : acc + product). If last: result <= new acc value, overflow <= group overflow state, out_valid <= 1.
  - Throughput: 1 beat/cycle when not stalled. Idle cycles (in_valid=0) propagate as bubbles that do not touch acc.
- out_valid clears on transfer edge unless a new last reaches S3 on the same edge, in which case it stays 1 with the new result (back-to-back groups, no gap).
- first && last on one beat: result = that single product.
- A beat with first=0 after a completed group continues accumulating from the retained acc value.
- Overflow detection at S3, for acc + product:
  - Unsigned: carry out of bit ACC_W-1.
  - Signed: operands same sign and sum sign differs.
  - Sticky per group; reset by a first beat; includes the first beat's own status (always 0 for first).
- SATURATE=1: on overflow, acc <= all-ones (unsigned), or 0x7F..F / 0x80..0 (signed, following the operand sign). Subsequent beats continue from the clamped value.
- result and overflow are stable while out_valid=1 and out_ready=0.

Test Plan:
- Unsigned, defaults: beats (3,4,first),(5,6),(7,8,last) back-to-back from E0 → out_valid at E4, result=98, overflow=0.
- Single beat first&last, a=b=2^64-1 → result=0xFFFFFFFFFFFFFFFE_0000000000000001, overflow=0.
- Two beats of (2^64-1)^2, SATURATE=0 → result=wrapped sum 0xFFFFFFFFFFFFFFFC_0000000000000002, overflow=1. Same stimulus with SATURATE=1 → result all-ones, overflow=1.
- SIGNED=1: (-3,5,first),(2,2,last) → result=-11 (0xFF..F5), overflow=0. (2^63-1)^2 accumulated 3× with SATURATE=1 → result=0x7FF..F, overflow=1.
- Backpressure: out_ready=0 while group 1 result is valid → in_ready=0, result held unchanged for 5 cycles. Raise out_ready → transfer; queued group 2 completes with its correct result, no beat lost or duplicated.
- Assert reset=0 mid-group (between edges) → out_valid=0 immediately. Release, then send (2,3,first,last) → result=6.

Source files
------------

// File: rtl/mac_pipe_if.sv
// Operand and result streams of mac_pipe bundled as one interface.
// The master side drives operand beats and result acceptance; the slave is the MAC.
`timescale 1ns/1ps
interface mac_pipe_if #(
  parameter int DATA_W = 64,
  parameter int ACC_W  = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              first;
  logic              last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
  logic              overflow;

  modport master (
    output in_valid, a, b, first, last, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, a, b, first, last, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/mac_pipe.sv
// Three-stage pipelined multiply-accumulate: operand register, product, accumulate.
// Groups are framed by first/last; a stalled result freezes every stage.
`timescale 1ns/1ps
module mac_pipe #(
  parameter int DATA_W   = 64,
  parameter int ACC_W    = 128,
  parameter bit SIGNED   = 1'b0,
  parameter bit SATURATE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  mac_pipe_if.slave  bus
);

  localparam int PROD_W = 2 * DATA_W;

  if (ACC_W < PROD_W) begin : g_width_check
    $error("mac_pipe: ACC_W must be at least 2*DATA_W");
  end

  // Full-width product, extended to the accumulator width.
  function automatic logic [ACC_W-1:0] ext_product(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y);
    logic [PROD_W-1:0] p;
    if (SIGNED) begin
      p = $signed({{DATA_W{x[DATA_W-1]}}, x}) * $signed({{DATA_W{y[DATA_W-1]}}, y});
      ext_product = ACC_W'($signed(p));
    end else begin
      p = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
      ext_product = ACC_W'(p);
    end
  endfunction

  // Returns {overflow, next accumulator} for acc + prod, clamped when saturating.
  function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] acc,
                                              input logic [ACC_W-1:0] prod);
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] val;
    logic             ovf;
    sum = {1'b0, acc} + {1'b0, prod};
    val = sum[ACC_W-1:0];
    if (SIGNED) begin
      ovf = (acc[ACC_W-1] == prod[ACC_W-1]) && (val[ACC_W-1] != acc[ACC_W-1]);
    end else begin
      ovf = sum[ACC_W];
    end
    if (ovf && SATURATE) begin
      if (SIGNED) begin
        val = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        val = {ACC_W{1'b1}};
      end
    end else begin
      val = sum[ACC_W-1:0];
    end
    acc_step = {ovf, val};
  endfunction

  logic              stall_s;
  logic              accept_s;
  logic              s1_valid_r;
  logic              s1_first_r;
  logic              s1_last_r;
  logic [DATA_W-1:0] s1_a_r;
  logic [DATA_W-1:0] s1_b_r;
  logic              s2_valid_r;
  logic              s2_first_r;
  logic              s2_last_r;
  logic [ACC_W-1:0]  s2_prod_r;
  logic [ACC_W-1:0]  acc_r;
  logic              grp_ovf_r;
  logic [ACC_W-1:0]  result_r;
  logic              overflow_r;
  logic              out_valid_r;
  logic [ACC_W:0]    step_s;
  logic [ACC_W-1:0]  acc_nxt_s;
  logic              ovf_nxt_s;

  // A held result blocks the whole pipe; in_ready also drops while reset is asserted.
  assign stall_s       = out_valid_r && !bus.out_ready;
  assign bus.in_ready  = reset && !stall_s;
  assign accept_s      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.overflow  = overflow_r;

  // Stage 1: capture the accepted operand beat; bubbles clear the valid bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_r <= 1'b0;
      s1_first_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_a_r     <= {DATA_W{1'b0}};
      s1_b_r     <= {DATA_W{1'b0}};
    end else if (!stall_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_first_r <= bus.first;
        s1_last_r  <= bus.last;
        s1_a_r     <= bus.a;
        s1_b_r     <= bus.b;
      end
    end
  end

  // Stage 2: multiply.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_r <= 1'b0;
      s2_first_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_prod_r  <= {ACC_W{1'b0}};
    end else if (!stall_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_first_r <= s1_first_r;
        s2_last_r  <= s1_last_r;
        s2_prod_r  <= ext_product(s1_a_r, s1_b_r);
      end
    end
  end

  // Stage 3 next state: a first beat restarts the sum and the sticky flag.
  always_comb begin
    step_s    = acc_step(acc_r, s2_prod_r);
    acc_nxt_s = step_s[ACC_W-1:0];
    ovf_nxt_s = grp_ovf_r | step_s[ACC_W];
    if (s2_first_r) begin
      acc_nxt_s = s2_prod_r;
      ovf_nxt_s = 1'b0;
    end else begin
      acc_nxt_s = step_s[ACC_W-1:0];
      ovf_nxt_s = grp_ovf_r | step_s[ACC_W];
    end
  end

  // Stage 3: accumulate and publish on last; a new last on a transfer edge keeps out_valid high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r       <= {ACC_W{1'b0}};
      grp_ovf_r   <= 1'b0;
      result_r    <= {ACC_W{1'b0}};
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (!stall_s) begin
      if (s2_valid_r) begin
        acc_r     <= acc_nxt_s;
        grp_ovf_r <= ovf_nxt_s;
      end
      if (s2_valid_r && s2_last_r) begin
        result_r    <= acc_nxt_s;
        overflow_r  <= ovf_nxt_s;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: three instances (unsigned wrap, unsigned saturate, signed saturate)
// share one operand stream; a reference model feeds per-instance scoreboards.
`timescale 1ns/1ps
module tb_mac_pipe;

  localparam int DW = 64;
  localparam int AW = 128;
  localparam logic [DW-1:0] DMAX    = {DW{1'b1}};
  localparam logic [AW-1:0] POS_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] NEG_MIN = {1'b1, {(AW-1){1'b0}}};

  logic clk = 1'b0;
  logic reset;
  logic in_valid, first, last, out_ready;
  logic [DW-1:0] a, b;

  always #5 clk = ~clk;

  logic [2:0]    ov, ovf, rdy;
  logic [AW-1:0] res [3];

  mac_pipe_if #(.DATA_W(DW), .ACC_W(AW)) ifs [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign ifs[g].in_valid  = in_valid;
    assign ifs[g].a         = a;
    assign ifs[g].b         = b;
    assign ifs[g].first     = first;
    assign ifs[g].last      = last;
    assign ifs[g].out_ready = out_ready;
    assign ov[g]  = ifs[g].out_valid;
    assign ovf[g] = ifs[g].overflow;
    assign rdy[g] = ifs[g].in_ready;
    assign res[g] = ifs[g].result;
    mac_pipe #(.DATA_W(DW), .ACC_W(AW), .SIGNED(g == 2), .SATURATE(g != 0)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifs[g])
    );
  end

  int total = 0;
  int bad   = 0;

  logic [AW:0]   q0 [$];
  logic [AW:0]   q1 [$];
  logic [AW:0]   q2 [$];
  logic [AW-1:0] m_acc [3];
  logic [2:0]    m_ovf;
  logic [AW-1:0] last_res [3];
  logic [2:0]    last_ovf;
  logic [AW:0]   mon_e;
  bit            mon_have;

  // Reference model: one accepted beat, computed with wide arithmetic and range checks.
  task automatic model_beat();
    logic [AW-1:0] p, nv;
    logic [AW:0] su;
    logic signed [AW+1:0] ss;
    logic o;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) p = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
      else        p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
      o = 1'b0;
      if (first) begin
        nv = p;
      end else if (k == 2) begin
        ss = $signed({{2{m_acc[k][AW-1]}}, m_acc[k]}) + $signed({{2{p[AW-1]}}, p});
        if (ss > $signed({2'b00, POS_MAX}))      begin o = 1'b1; nv = POS_MAX; end
        else if (ss < $signed({2'b11, NEG_MIN})) begin o = 1'b1; nv = NEG_MIN; end
        else nv = ss[AW-1:0];
      end else begin
        su = {1'b0, m_acc[k]} + {1'b0, p};
        o  = su[AW];
        nv = (o && k == 1) ? {AW{1'b1}} : su[AW-1:0];
      end
      m_ovf[k] = first ? o : (m_ovf[k] | o);
      m_acc[k] = nv;
      if (last) begin
        case (k)
          0: q0.push_back({m_ovf[k], m_acc[k]});
          1: q1.push_back({m_ovf[k], m_acc[k]});
          default: q2.push_back({m_ovf[k], m_acc[k]});
        endcase
      end
    end
  endtask

  // Scoreboard: every transferred result is popped and compared.
  always @(negedge clk) begin
    if (reset && out_ready) begin
      for (int k = 0; k < 3; k++) begin
        if (ov[k]) begin
          mon_have = 1'b0;
          case (k)
            0: if (q0.size() != 0) begin mon_e = q0.pop_front(); mon_have = 1'b1; end
            1: if (q1.size() != 0) begin mon_e = q1.pop_front(); mon_have = 1'b1; end
            default: if (q2.size() != 0) begin mon_e = q2.pop_front(); mon_have = 1'b1; end
          endcase
          total++;
          if (!mon_have) begin
            bad++;
            $display("FAIL sb%0d unexpected result: got ovf=%b res=%h, required none", k, ovf[k], res[k]);
          end else if ({ovf[k], res[k]} !== mon_e) begin
            bad++;
            $display("FAIL sb%0d result: got ovf=%b res=%h, required ovf=%b res=%h",
                     k, ovf[k], res[k], mon_e[AW], mon_e[AW-1:0]);
          end
          last_res[k] = res[k];
          last_ovf[k] = ovf[k];
        end
      end
    end
  end

  task automatic wait_accept();
    bit done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (rdy[0]) done = 1'b1;
    end
    if (done) begin
      @(posedge clk);
      model_beat();
    end else begin
      total++;
      bad++;
      $display("FAIL accept timeout: in_ready=%b, required 1 within 40 cycles", rdy);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] va, input logic [DW-1:0] vb,
                      input logic vf, input logic vl);
    a = va; b = vb; first = vf; last = vl; in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(posedge clk);
      #2;
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0 && ov == 3'b000) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain: pending %0d/%0d/%0d out_valid=%b, required all empty",
               q0.size(), q1.size(), q2.size(), ov);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = {DW{1'b0}}; b = {DW{1'b0}}; first = 1'b0; last = 1'b0;
    for (int k = 0; k < 3; k++) m_acc[k] = {AW{1'b0}};
    m_ovf = 3'b000;
    #1 reset = 1'b0;
    #12;
    total++;
    if (rdy !== 3'b000 || ov !== 3'b000 || ovf !== 3'b000) begin
      bad++;
      $display("FAIL reset flags: in_ready=%b out_valid=%b overflow=%b, required 000", rdy, ov, ovf);
    end
    total++;
    if (res[0] !== {AW{1'b0}} || res[2] !== {AW{1'b0}}) begin
      bad++;
      $display("FAIL reset result: got %h / %h, required 0", res[0], res[2]);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (rdy !== 3'b111) begin
      bad++;
      $display("FAIL release in_ready: got %b, required 111", rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned_sum();
    send(64'd3, 64'd4, 1'b1, 1'b0);
    send(64'd5, 64'd6, 1'b0, 1'b0);
    send(64'd7, 64'd8, 1'b0, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      total++;
      if (ov !== ((c == 4) ? 3'b111 : 3'b000)) begin
        bad++;
        $display("FAIL latency E%0d: out_valid=%b, required %s", c, ov, (c == 4) ? "111" : "000");
      end
      if (c < 4) begin @(posedge clk); #1; end
    end
    wait_drain();
    total++;
    if (last_res[0] !== 128'd98 || last_ovf[0] !== 1'b0 || last_res[2] !== 128'd98) begin
      bad++;
      $display("FAIL sum98: got %0d ovf=%b signed %0d, required 98 ovf=0", last_res[0], last_ovf[0], last_res[2]);
    end
  endtask

  task automatic test_single_max();
    send(DMAX, DMAX, 1'b1, 1'b1);
    wait_drain();
    total++;
    if (last_res[0] !== 128'hFFFFFFFFFFFFFFFE_0000000000000001 || last_ovf[0] !== 1'b0) begin
      bad++;
      $display("FAIL single max: got %h ovf=%b, required fffffffffffffffe0000000000000001 ovf=0",
               last_res[0], last_ovf[0]);
    end
    total++;
    if (last_res[2] !== 128'd1) begin
      bad++;
      $display("FAIL single max signed: got %h, required 1", last_res[2]);
    end
  endtask

  task automatic test_overflow_sat();
    send(DMAX, DMAX, 1'b1, 1'b0);
    send(DMAX, DMAX, 1'b0, 1'b1);
    wait_drain();
    total++;
    if (last_res[0] !== 128'hFFFFFFFFFFFFFFFC_0000000000000002 || last_ovf[0] !== 1'b1) begin
      bad++;
      $display("FAIL wrap: got %h ovf=%b, required fffffffffffffffc0000000000000002 ovf=1",
               last_res[0], last_ovf[0]);
    end
    total++;
    if (last_res[1] !== {AW{1'b1}} || last_ovf[1] !== 1'b1) begin
      bad++;
      $display("FAIL saturate: got %h ovf=%b, required all ones ovf=1", last_res[1], last_ovf[1]);
    end
  endtask

  task automatic test_signed();
    send(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 1'b0);
    send(64'd2, 64'd2, 1'b0, 1'b1);
    wait_drain();
    total++;
    if (last_res[2] !== 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF5 || last_ovf[2] !== 1'b0) begin
      bad++;
      $display("FAIL signed -11: got %h ovf=%b, required ...fff5 ovf=0", last_res[2], last_ovf[2]);
    end
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    wait_drain();
    total++;
    if (last_res[2] !== POS_MAX || last_ovf[2] !== 1'b1) begin
      bad++;
      $display("FAIL signed sat: got %h ovf=%b, required 7fff..ffff ovf=1", last_res[2], last_ovf[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ra, rb;
    logic rf, rl;
    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? DMAX : {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? DMAX : {$urandom, $urandom};
      rf = (i == 0) || ($urandom_range(0, 3) == 0);
      rl = (i == 23) || ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
      send(ra, rb, rf, rl);
    end
    send(64'd7, 64'd7, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(64'd100 + 64'(i), 64'd3, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      total++;
      if (ov !== 3'b111) begin
        bad++;
        $display("FAIL no-gap cycle %0d: out_valid=%b, required 111", c, ov);
      end
      @(posedge clk);
      #1;
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(64'd10, 64'd10, 1'b1, 1'b1);
    send(64'd3, 64'd3, 1'b1, 1'b0);
    send(64'd4, 64'd4, 1'b0, 1'b1);
    a = 64'd5; b = 64'd5; first = 1'b1; last = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (rdy !== 3'b000 || ov !== 3'b111 || res[0] !== 128'd100 || ovf[0] !== 1'b0) begin
        bad++;
        $display("FAIL hold cycle %0d: in_ready=%b out_valid=%b res=%0d, required 000 111 100",
                 c, rdy, ov, res[0]);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_accept();
    wait_drain();
    total++;
    if (last_res[0] !== 128'd25) begin
      bad++;
      $display("FAIL after stall: got %0d, required 25", last_res[0]);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(64'd4, 64'd4, 1'b1, 1'b1);
    send(64'd1, 64'd1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (ov !== 3'b111) begin
      bad++;
      $display("FAIL pre-reset out_valid: got %b, required 111", ov);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if (ov !== 3'b000 || rdy !== 3'b000 || res[0] !== {AW{1'b0}}) begin
      bad++;
      $display("FAIL mid reset: out_valid=%b in_ready=%b res=%h, required 000 000 0", ov, rdy, res[0]);
    end
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 0; k < 3; k++) m_acc[k] = {AW{1'b0}};
    m_ovf = 3'b000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (rdy !== 3'b111) begin
      bad++;
      $display("FAIL post-reset in_ready: got %b, required 111", rdy);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(64'd2, 64'd3, 1'b1, 1'b1);
    wait_drain();
    total++;
    if (last_res[0] !== 128'd6 || last_res[1] !== 128'd6 || last_res[2] !== 128'd6) begin
      bad++;
      $display("FAIL after reset: got %0d/%0d/%0d, required 6", last_res[0], last_res[1], last_res[2]);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_sum();
    test_single_max();
    test_overflow_sat();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
